mib_slave: RTL

- Downstream partner of mib_master on the 16-bit multiplexed MIB bus.
- Decodes MIB address/data phases addressed to this FPGA.
- Replays each decoded access as a single local intf_cmd transaction.
- Returns write ack, or read data plus ack, to the master.
- Instantiated once per FPGA top (e.g. cs03_top) and drives the local register fabric.

---
 rtl/mib_pkg.sv | 35 +++
 rtl/intf_cmd.sv | 31 +++
 rtl/mib_cmd_timer.sv | 37 +++
 rtl/mib_slave.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mib_pkg.sv
// Shared MIB bus definitions used by mib_slave and mib_master.
// Holds FSM state encoding, frame geometry and address-decode helper.
package mib_pkg;

    localparam int MIB_ADDR_BITS   = 24;
    localparam int MIB_DATA_BITS   = 32;
    localparam int MIB_AD_BITS     = 16;

    localparam int MIB_MSN_HI      = 23;
    localparam int MIB_MSN_LO      = 20;

    localparam int MIB_ADDR_WORDS  = 2;
    localparam int MIB_WDATA_WORDS = 2;
    localparam int MIB_RDATA_WORDS = 2;

    typedef enum logic [3:0] {
        IDLE,
        ADDR2,
        WR_HI,
        WR_LO,
        ISSUE,
        WAIT_ACK,
        RD_HI,
        RD_LO,
        WR_ACK
    } state_t;

    function automatic logic mib_addr_hit(
        input logic [MIB_ADDR_BITS-1:0] addr,
        input logic [3:0]               msn
    );
        return addr[MIB_MSN_HI:MIB_MSN_LO] == msn;
    endfunction

endpackage

// File: rtl/intf_cmd.sv
// Local register-fabric command bus: one sel strobe per access,
// completed by an ack carrying read data.
interface intf_cmd;
    import mib_pkg::*;

    logic                     sel;
    logic                     rd_wr_n;
    logic [MIB_ADDR_BITS-1:0] byte_addr;
    logic [MIB_DATA_BITS-1:0] wdata;
    logic                     ack;
    logic [MIB_DATA_BITS-1:0] rdata;

    modport master (
        output sel,
        output rd_wr_n,
        output byte_addr,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  sel,
        input  rd_wr_n,
        input  byte_addr,
        input  wdata,
        output ack,
        output rdata
    );

endinterface

// File: rtl/mib_cmd_timer.sv
// Loadable down-counter; o_last flags the final counting clock and
// o_expire is a registered pulse one clock after it.
module mib_cmd_timer #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_last,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;
    logic         r_expire;
    logic         w_last;

    assign w_last   = (r_cnt == W'(1));
    assign o_last   = w_last;
    assign o_expire = r_expire;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_expire <= 1'b0;
        end else begin
            r_expire <= i_en && !i_load && w_last;
            if (i_load) begin
                r_cnt <= i_load_val;
            end else if (i_en && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mib_slave.sv
// MIB bus slave: decodes multiplexed address/data frames for this FPGA
// and replays each one as a single local cmd transaction.
module mib_slave
    import mib_pkg::*;
#(
    parameter logic [3:0] P_MIB_MSN              = 4'h0,
    parameter int         P_CMD_ACK_TIMEOUT_CLKS = 16,
    parameter int         ADDR_BITS              = 24,
    parameter int         DATA_BITS              = 32
) (
    input  logic                   i_sysclk,
    input  logic                   i_srst,
    input  logic                   i_mib_start,
    input  logic                   i_mib_rd_wr_n,
    input  logic [MIB_AD_BITS-1:0] i_mib_ad,
    output logic [MIB_AD_BITS-1:0] o_mib_ad,
    output logic                   o_mib_ad_high_z,
    output logic                   o_mib_slave_ack,
    output logic                   o_cmd_timeout,
    intf_cmd.master                cmd_master
);

    localparam int TW = $clog2(P_CMD_ACK_TIMEOUT_CLKS) + 1;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_rd_wr_n;
    logic [ADDR_BITS-1:0]     r_addr;
    logic [DATA_BITS-1:0]     r_wdata;
    logic [DATA_BITS-1:0]     r_rdata;
    logic                     r_sel;
    logic                     r_ack;
    logic                     r_high_z;
    logic [MIB_AD_BITS-1:0]   r_ad;
    logic                     w_new_a1;
    logic                     w_hit;
    logic                     w_in_cmd;
    logic                     w_tmr_en;
    logic                     w_tmr_last;
    logic                     w_tmr_expire;

    assign w_hit    = mib_addr_hit({r_addr[23:16], i_mib_ad}, P_MIB_MSN);
    assign w_in_cmd = (r_state == ISSUE) || (r_state == WAIT_ACK);
    assign w_tmr_en = (r_state == WAIT_ACK) && !cmd_master.ack;

    // A start inside an unfinished frame header restarts decoding.
    assign w_new_a1 = i_mib_start &&
                      ((r_state == IDLE)  || (r_state == ADDR2) ||
                       (r_state == WR_HI) || (r_state == WR_LO));

    mib_cmd_timer #(
        .W (TW)
    ) u_timer (
        .i_clk      (i_sysclk),
        .i_rst      (i_srst),
        .i_load     (r_state == ISSUE),
        .i_load_val (TW'(P_CMD_ACK_TIMEOUT_CLKS - 1)),
        .i_en       (w_tmr_en),
        .o_last     (w_tmr_last),
        .o_expire   (w_tmr_expire)
    );

    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_mib_start) w_next = ADDR2;
            end
            ADDR2: begin
                if (i_mib_start)    w_next = ADDR2;
                else if (!w_hit)    w_next = IDLE;
                else if (r_rd_wr_n) w_next = ISSUE;
                else                w_next = WR_HI;
            end
            WR_HI: begin
                w_next = i_mib_start ? ADDR2 : WR_LO;
            end
            WR_LO: begin
                w_next = i_mib_start ? ADDR2 : ISSUE;
            end
            ISSUE, WAIT_ACK: begin
                if (cmd_master.ack) begin
                    w_next = r_rd_wr_n ? RD_HI : WR_ACK;
                end else if ((r_state == WAIT_ACK) && w_tmr_last) begin
                    w_next = IDLE;
                end else begin
                    w_next = WAIT_ACK;
                end
            end
            RD_HI:   w_next = RD_LO;
            RD_LO:   w_next = IDLE;
            WR_ACK:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            r_rd_wr_n <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_sel     <= 1'b0;
            r_ack     <= 1'b0;
            r_high_z  <= 1'b1;
            r_ad      <= '0;
        end else begin
            if (w_new_a1) begin
                r_rd_wr_n     <= i_mib_rd_wr_n;
                r_addr[23:16] <= i_mib_ad[7:0];
            end else if (r_state == ADDR2) begin
                r_addr[15:0]  <= i_mib_ad;
            end else if (r_state == WR_HI) begin
                r_wdata[31:16] <= i_mib_ad;
            end else if (r_state == WR_LO) begin
                r_wdata[15:0]  <= i_mib_ad;
            end

            if (w_in_cmd && cmd_master.ack) begin
                r_rdata <= cmd_master.rdata;
            end

            r_sel    <= (w_next == ISSUE);
            r_ack    <= (w_next == RD_HI) || (w_next == RD_LO) ||
                        (w_next == WR_ACK);
            r_high_z <= !((w_next == RD_HI) || (w_next == RD_LO));

            if (w_next == RD_HI) begin
                r_ad <= cmd_master.rdata[31:16];
            end else if (w_next == RD_LO) begin
                r_ad <= r_rdata[15:0];
            end else begin
                r_ad <= '0;
            end
        end
    end

    assign o_mib_ad             = r_ad;
    assign o_mib_ad_high_z      = r_high_z;
    assign o_mib_slave_ack      = r_ack;
    assign o_cmd_timeout        = w_tmr_expire;
    assign cmd_master.sel       = r_sel;
    assign cmd_master.rd_wr_n   = r_rd_wr_n;
    assign cmd_master.byte_addr = r_addr;
    assign cmd_master.wdata     = r_wdata;

endmodule
